fmul_share_ctrl: RTL

//  Round-robin scheduler sharing one pipelined 24-bit float multiplier (sign[23], exp[22:16], mantissa[15:0])

---
 rtl/float_pkg.sv | 13 +
 rtl/fmul_res_fifo.sv | 68 ++++++
 rtl/fmul_share_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// Field layout of the 24-bit float used by the shared multiplier and its
// schedulers: sign[23], exponent[22:16], mantissa[15:0].
package float_pkg;

    localparam int FLOAT_W  = 24;
    localparam int SIGN_BIT = 23;
    localparam int EXP_MSB  = 22;
    localparam int EXP_LSB  = 16;
    localparam int MAN_W    = 16;

    typedef logic [FLOAT_W-1:0] float_t;

endpackage

// File: rtl/fmul_res_fifo.sv
// Circular result buffer. Push and pop in the same cycle both take effect,
// including when full. A pop while empty is ignored. The head reads as zero
// while empty so nothing stale is ever presented downstream.
module fmul_res_fifo
    import float_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_eff;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_eff = pop_i && (count_q != '0);
    assign count_o = count_q;
    assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop_eff) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push_i && !pop_eff) begin
                count_q <= count_q + 1'b1;
            end else if (!push_i && pop_eff) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because occupancy gates the head.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Upstream credit accounting must never let a push land in a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push_i && !pop_eff && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fmul_share_ctrl.sv
// Round-robin front end sharing one pipelined float multiplier among several
// requesters. Grants at most one operand pair per cycle, tracks each issue with
// a requester tag that walks alongside the fixed-latency multiplier, and
// buffers results (plus flags) so they come back in issue order.
module fmul_share_ctrl
    import float_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int MUL_LATENCY = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FLOAT_W-1:0] req_a,
    input  logic [NUM_REQ*FLOAT_W-1:0] req_b,
    output logic [FLOAT_W-1:0]         mul_a,
    output logic [FLOAT_W-1:0]         mul_b,
    input  logic [FLOAT_W-1:0]         mul_result,
    input  logic                       mul_overflow,
    input  logic                       mul_underflow,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [FLOAT_W-1:0]         res_data,
    output logic                       res_overflow,
    output logic                       res_underflow,
    output logic [ID_W-1:0]            res_id,
    output logic                       busy
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W   = CNT_W + 1;
    localparam int ENTRY_W = 2 + FLOAT_W + ID_W;

    logic [ID_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]   inflight_q;
    logic [CNT_W-1:0]   fifo_count;
    logic               credit_ok;
    logic               hs;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    cand;
    logic [FLOAT_W-1:0] a_sel;
    logic [FLOAT_W-1:0] b_sel;

    logic [MUL_LATENCY:0] tag_v_q;
    logic [ID_W-1:0]      tag_id_q [MUL_LATENCY+1];
    logic                 capture;

    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    // Every issued op holds one credit from grant until it leaves the buffer;
    // a same-cycle pop only frees its credit once the count register updates.
    assign credit_ok = (SUM_W'(inflight_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);

    // Round-robin search starting just after the last winner, gated by credit.
    always_comb begin
        hs        = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!hs && req_valid[cand]) begin
                hs     = 1'b1;
                gnt_id = cand;
            end
        end
        if (!credit_ok || !rst) begin
            hs = 1'b0;
        end
        if (hs) begin
            req_ready[gnt_id] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                a_sel = req_a[i*FLOAT_W +: FLOAT_W];
                b_sel = req_b[i*FLOAT_W +: FLOAT_W];
            end
        end
    end

    // Register the granted operand pair toward the multiplier; hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a    <= '0;
            mul_b    <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
        end else if (hs) begin
            mul_a    <= a_sel;
            mul_b    <= b_sel;
            rr_ptr_q <= gnt_id;
        end
    end

    // Tag valid bits shadow the multiplier pipe, one stage past its latency,
    // so the last stage lines up with mul_result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v_q <= '0;
        end else begin
            tag_v_q <= {tag_v_q[MUL_LATENCY-1:0], hs};
        end
    end

    // Requester IDs ride along with the valid bits; only valid stages matter.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= gnt_id;
        for (int s = 1; s <= MUL_LATENCY; s++) begin
            tag_id_q[s] <= tag_id_q[s-1];
        end
    end

    assign capture = tag_v_q[MUL_LATENCY];

    // Ops between grant and capture into the result buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
        end else if (hs && !capture) begin
            inflight_q <= inflight_q + 1'b1;
        end else if (!hs && capture) begin
            inflight_q <= inflight_q - 1'b1;
        end
    end

    assign fifo_wdata = {tag_id_q[MUL_LATENCY], mul_overflow, mul_underflow, mul_result};

    fmul_res_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (capture),
        .pop_i   (res_ready),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign res_valid     = (fifo_count != '0);
    assign res_data      = fifo_rdata[FLOAT_W-1:0];
    assign res_underflow = fifo_rdata[FLOAT_W];
    assign res_overflow  = fifo_rdata[FLOAT_W+1];
    assign res_id        = fifo_rdata[ENTRY_W-1 -: ID_W];
    assign busy          = (inflight_q != '0) || res_valid;

endmodule
